arbiter_rr_multi: RTL and testbench

//  Parametrised successor to the single-source command arbiter. Merges NUM_SRC request FIFOs

---
 rtl/arbiter_rr_multi_if.sv | 34 +++
 rtl/arbiter_rr_multi.sv | 136 +++++++++++++
 tb/tb_arbiter_rr_multi.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr_multi_if.sv
// Command-merge bus between the request sources, the maintenance requesters
// and the DRAM command FSM. The arbiter uses the master modport; the
// surrounding environment uses the slave modport.
interface arbiter_rr_multi_if #(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 32,
    parameter int CMD_W   = 3
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*CMD_W-1:0]  src_cmd;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_pop;
    logic                      refresh_req;
    logic                      refresh_ack;
    logic                      scrub_req;
    logic                      scrub_ack;
    logic                      out_valid;
    logic [CMD_W-1:0]          out_cmd;
    logic [ADDR_W-1:0]         out_addr;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    modport master (
        input  src_valid, src_cmd, src_addr, refresh_req, scrub_req, out_ready,
        output src_pop, refresh_ack, scrub_ack, out_valid, out_cmd, out_addr, out_src
    );

    modport slave (
        output src_valid, src_cmd, src_addr, refresh_req, scrub_req, out_ready,
        input  src_pop, refresh_ack, scrub_ack, out_valid, out_cmd, out_addr, out_src
    );
endinterface

// File: rtl/arbiter_rr_multi.sv
// Multi-source DRAM command arbiter. Refresh always wins, scrub wins when
// the FIFOs are idle or after it has been bypassed SCRUB_MAX_WAIT times,
// otherwise the FIFO sources share the slot round-robin. A single output
// register reloads in the same cycle it is accepted, so a steady stream
// flows at one command per clock with no bubble.
module arbiter_rr_multi #(
    parameter int               NUM_SRC        = 4,
    parameter int               ADDR_W         = 32,
    parameter int               CMD_W          = 3,
    parameter int               SCRUB_MAX_WAIT = 16,
    parameter logic [CMD_W-1:0] CMD_NOP        = 3'd0,
    parameter logic [CMD_W-1:0] CMD_REFRESH    = 3'd3,
    parameter logic [CMD_W-1:0] CMD_SCRUB      = 3'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    arbiter_rr_multi_if.master         bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int AGE_W = $clog2(SCRUB_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(SCRUB_MAX_WAIT);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    logic               outValid_q, outValid_d;
    logic [CMD_W-1:0]   outCmd_q,   outCmd_d;
    logic [ADDR_W-1:0]  outAddr_q,  outAddr_d;
    logic [SRC_W-1:0]   outSrc_q,   outSrc_d;
    logic [SRC_W-1:0]   rrPtr_q,    rrPtr_d;
    logic [AGE_W-1:0]   scrubAge_q, scrubAge_d;

    logic               load;
    logic               anyValid;
    logic [SRC_W-1:0]   winIdx;
    logic [NUM_SRC-1:0] srcPop;
    logic               refreshAck;
    logic               scrubAck;

    // First valid source at or after the pointer, wrapping past the last index.
    function automatic logic [SRC_W-1:0] pickWinner(input logic [NUM_SRC-1:0] valid,
                                                    input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!found && valid[idx]) begin
                win   = idx[SRC_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign anyValid = |bus.src_valid;
    assign winIdx   = pickWinner(bus.src_valid, rrPtr_q);
    assign load     = !outValid_q || bus.out_ready;

    // Choose what the output register takes next and who gets the pop/ack.
    always_comb begin
        outValid_d = outValid_q;
        outCmd_d   = outCmd_q;
        outAddr_d  = outAddr_q;
        outSrc_d   = outSrc_q;
        rrPtr_d    = rrPtr_q;
        scrubAge_d = scrubAge_q;
        srcPop     = '0;
        refreshAck = 1'b0;
        scrubAck   = 1'b0;
        if (load) begin
            if (bus.refresh_req) begin
                outValid_d = 1'b1;
                outCmd_d   = CMD_REFRESH;
                outAddr_d  = '0;
                outSrc_d   = '0;
                refreshAck = 1'b1;
            end else if (bus.scrub_req && (!anyValid || scrubAge_q == AGE_MAX)) begin
                outValid_d = 1'b1;
                outCmd_d   = CMD_SCRUB;
                outAddr_d  = '0;
                outSrc_d   = '0;
                scrubAck   = 1'b1;
                scrubAge_d = '0;
            end else if (anyValid) begin
                outValid_d     = 1'b1;
                outCmd_d       = bus.src_cmd[winIdx*CMD_W +: CMD_W];
                outAddr_d      = bus.src_addr[winIdx*ADDR_W +: ADDR_W];
                outSrc_d       = winIdx;
                srcPop[winIdx] = 1'b1;
                rrPtr_d        = (winIdx == LAST_SRC) ? '0 : winIdx + SRC_W'(1);
                if (bus.scrub_req && scrubAge_q != AGE_MAX) begin
                    scrubAge_d = scrubAge_q + AGE_W'(1);
                end
            end else begin
                outValid_d = 1'b0;
                outCmd_d   = CMD_NOP;
            end
        end
        if (!bus.scrub_req) begin
            scrubAge_d = '0;
        end
        if (rst) begin
            srcPop     = '0;
            refreshAck = 1'b0;
            scrubAck   = 1'b0;
        end
    end

    // Output register, round-robin pointer and scrub age, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outCmd_q   <= CMD_NOP;
            outAddr_q  <= '0;
            outSrc_q   <= '0;
            rrPtr_q    <= '0;
            scrubAge_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            outCmd_q   <= outCmd_d;
            outAddr_q  <= outAddr_d;
            outSrc_q   <= outSrc_d;
            rrPtr_q    <= rrPtr_d;
            scrubAge_q <= scrubAge_d;
        end
    end

    assign bus.src_pop     = srcPop;
    assign bus.refresh_ack = refreshAck;
    assign bus.scrub_ack   = scrubAck;
    assign bus.out_valid   = outValid_q;
    assign bus.out_cmd     = outCmd_q;
    assign bus.out_addr    = outAddr_q;
    assign bus.out_src     = outSrc_q;
endmodule

// File: tb/tb_arbiter_rr_multi.sv
// Directed bench for arbiter_rr_multi: reset, round-robin order, wrap/skip,
// refresh preemption, scrub aging, backpressure, idle and mid-run reset.
module tb_arbiter_rr_multi;
    localparam int       NUM_SRC = 4;
    localparam int       ADDR_W  = 32;
    localparam int       CMD_W   = 3;
    localparam logic [2:0] NOP     = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] REFRESH = 3'd3;
    localparam logic [2:0] SCRUB   = 3'd4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    arbiter_rr_multi_if #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .CMD_W(CMD_W)) bus ();

    arbiter_rr_multi #(
        .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .SCRUB_MAX_WAIT(16),
        .CMD_NOP(NOP), .CMD_REFRESH(REFRESH), .CMD_SCRUB(SCRUB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Even sources issue reads, odd sources issue writes.
    function automatic logic [2:0] expCmd(input int i);
        return (i % 2 == 0) ? READ : WRITE;
    endfunction

    function automatic logic [31:0] expAddr(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [3:0] oneHot(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return v << i;
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic rf,
                                 input logic sc, input logic rdy);
        rst             = r;
        bus.src_valid   = v;
        bus.refresh_req = rf;
        bus.scrub_req   = sc;
        bus.out_ready   = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_cmd[i*CMD_W +: CMD_W]    = expCmd(i);
            bus.src_addr[i*ADDR_W +: ADDR_W] = expAddr(i);
        end

        // Reset with every request active.
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_cmd", 64'(bus.out_cmd), 64'(NOP));
        checkOutput("rst_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("rst_src", 64'(bus.out_src), 64'd0);
        checkOutput("rst_pop", 64'(bus.src_pop), 64'd0);
        checkOutput("rst_rack", 64'(bus.refresh_ack), 64'd0);
        checkOutput("rst_sack", 64'(bus.scrub_ack), 64'd0);

        // First grant after release is refresh.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
        checkOutput("rel_rack", 64'(bus.refresh_ack), 64'd1);
        checkOutput("rel_sack", 64'(bus.scrub_ack), 64'd0);
        checkOutput("rel_pop", 64'(bus.src_pop), 64'd0);
        tick();
        checkOutput("rel_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("rel_cmd", 64'(bus.out_cmd), 64'(REFRESH));
        checkOutput("rel_addr", 64'(bus.out_addr), 64'd0);

        // Round-robin with every source valid: 0,1,2,3,0,1,2.
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("rr_pop%0d", i), 64'(bus.src_pop), 64'(oneHot(i % 4)));
            tick();
            checkOutput($sformatf("rr_valid%0d", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("rr_src%0d", i), 64'(bus.out_src), 64'(i % 4));
            checkOutput($sformatf("rr_cmd%0d", i), 64'(bus.out_cmd), 64'(expCmd(i % 4)));
            checkOutput($sformatf("rr_addr%0d", i), 64'(bus.out_addr), 64'(expAddr(i % 4)));
        end

        // Pointer now at 3: sources 0 and 2 only, so 0 then 2, then pointer is 3.
        applyStimulus(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_pop0", 64'(bus.src_pop), 64'b0001);
        tick();
        checkOutput("wrap_src0", 64'(bus.out_src), 64'd0);
        checkOutput("wrap_pop1", 64'(bus.src_pop), 64'b0100);
        tick();
        checkOutput("wrap_src1", 64'(bus.out_src), 64'd2);
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_pop2", 64'(bus.src_pop), 64'b1000);
        tick();
        checkOutput("wrap_src2", 64'(bus.out_src), 64'd3);

        // Refresh preempts FIFOs and scrub.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
        checkOutput("pre_rack", 64'(bus.refresh_ack), 64'd1);
        checkOutput("pre_sack", 64'(bus.scrub_ack), 64'd0);
        checkOutput("pre_pop", 64'(bus.src_pop), 64'd0);
        tick();
        checkOutput("pre_cmd", 64'(bus.out_cmd), 64'(REFRESH));
        checkOutput("pre_src", 64'(bus.out_src), 64'd0);

        // Scrub bypassed by 16 FIFO grants (pointer still 0), then forced.
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
        for (int g = 0; g < 16; g++) begin
            checkOutput($sformatf("age_pop%0d", g), 64'(bus.src_pop), 64'(oneHot(g % 4)));
            checkOutput($sformatf("age_sack%0d", g), 64'(bus.scrub_ack), 64'd0);
            tick();
            checkOutput($sformatf("age_src%0d", g), 64'(bus.out_src), 64'(g % 4));
        end
        checkOutput("age_force_sack", 64'(bus.scrub_ack), 64'd1);
        checkOutput("age_force_pop", 64'(bus.src_pop), 64'd0);
        tick();
        checkOutput("age_force_cmd", 64'(bus.out_cmd), 64'(SCRUB));
        checkOutput("age_force_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("age_force_src", 64'(bus.out_src), 64'd0);

        // A fresh scrub request starts from age 0, so FIFO traffic goes first.
        checkOutput("age_clr_pop", 64'(bus.src_pop), 64'b0001);
        checkOutput("age_clr_sack", 64'(bus.scrub_ack), 64'd0);
        tick();
        checkOutput("age_clr_src", 64'(bus.out_src), 64'd0);

        // Scrub with no FIFO traffic wins immediately.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_scrub_sack", 64'(bus.scrub_ack), 64'd1);
        tick();
        checkOutput("idle_scrub_cmd", 64'(bus.out_cmd), 64'(SCRUB));

        // Backpressure: hold source 1's command for 5 cycles despite a refresh request.
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_load_pop", 64'(bus.src_pop), 64'b0010);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp_pop%0d", c), 64'(bus.src_pop), 64'd0);
            checkOutput($sformatf("bp_rack%0d", c), 64'(bus.refresh_ack), 64'd0);
            checkOutput($sformatf("bp_sack%0d", c), 64'(bus.scrub_ack), 64'd0);
            tick();
            checkOutput($sformatf("bp_valid%0d", c), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("bp_src%0d", c), 64'(bus.out_src), 64'd1);
            checkOutput($sformatf("bp_cmd%0d", c), 64'(bus.out_cmd), 64'(WRITE));
            checkOutput($sformatf("bp_addr%0d", c), 64'(bus.out_addr), 64'(expAddr(1)));
        end
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_rel_rack", 64'(bus.refresh_ack), 64'd1);
        tick();
        checkOutput("bp_rel_cmd", 64'(bus.out_cmd), 64'(REFRESH));
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_next_pop", 64'(bus.src_pop), 64'b0100);
        tick();
        checkOutput("bp_next_src", 64'(bus.out_src), 64'd2);

        // Nothing requested: valid drops, cmd NOP, addr/src hold.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_pop", 64'(bus.src_pop), 64'd0);
        tick();
        checkOutput("idle_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("idle_cmd", 64'(bus.out_cmd), 64'(NOP));
        checkOutput("idle_src", 64'(bus.out_src), 64'd2);
        checkOutput("idle_addr", 64'(bus.out_addr), 64'(expAddr(2)));

        // Reset drops a pending, stalled command.
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_pop", 64'(bus.src_pop), 64'b1000);
        tick();
        checkOutput("mid_src", 64'(bus.out_src), 64'd3);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_rst_pop", 64'(bus.src_pop), 64'd0);
        tick();
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_cmd", 64'(bus.out_cmd), 64'(NOP));
        checkOutput("mid_rst_src", 64'(bus.out_src), 64'd0);
        checkOutput("mid_rst_addr", 64'(bus.out_addr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
